// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - Start/Busy/Done handshake and operand/result bundle for div_unit
interface div_unit_if #(parameter int WIDTH = 32);
    logic             Start;
    logic             Signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Busy;
    logic             Done;
    logic             DivZero;

    modport master (
        output Start, Signed, A, B,
        input  Hi, Lo, Busy, Done, DivZero
    );

    modport slave (
        input  Start, Signed, A, B,
        output Hi, Lo, Busy, Done, DivZero
    );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multicycle restoring divider for DIV/DIVU, Hi=remainder, Lo=quotient
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    div_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               sgn_q;
    logic [WIDTH-1:0]   dmag;
    logic [WIDTH-1:0]   rem, quo;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q, neg_r;
    logic [WIDTH-1:0]   hi, lo;
    logic               busy, done, div_zero;

    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;

    // Remainder stays below the divisor, so WIDTH+1 bits hold the shifted value
    // and the sign of trial decides the quotient bit.
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dmag};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            dmag     <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        a_q   <= bus.A;
                        b_q   <= bus.B;
                        sgn_q <= bus.Signed;
                        busy  <= 1'b1;
                        state <= PREP;
                    end
                end
                PREP: begin
                    if (b_q == '0) begin
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                        state    <= DONE;
                    end else begin
                        dmag  <= (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
                        quo   <= (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
                        rem   <= '0;
                        cnt   <= '0;
                        neg_q <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                        neg_r <= sgn_q & a_q[WIDTH-1];
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    lo    <= neg_q ? -quo : quo;
                    hi    <= neg_r ? -rem : rem;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Hi      = hi;
    assign bus.Lo      = lo;
    assign bus.Busy    = busy;
    assign bus.Done    = done;
    assign bus.DivZero = div_zero;
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed vector bench for div_unit
module tb_div_unit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output logic dz);
        @(negedge clk);
        bus.A = a; bus.B = b; bus.Signed = s; bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        lat = -1;
        dz  = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.Done) begin
                lat = k;
                dz  = bus.DivZero;
                break;
            end
        end
    endtask

    int   lat;
    logic dz;
    int   ndone;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bus.Start = 1'b0; bus.Signed = 1'b0; bus.A = '0; bus.B = '0;
        rst_n = 1'b0;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          34, 1'b0};
        vecs[1] = '{32'h0000_1234,  32'd0,          1'b0, 32'd14,         32'd2,          1,  1'b1};
        vecs[2] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  34, 1'b0};
        vecs[3] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          34, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          34, 1'b0};
        vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          34, 1'b0};
        vecs[6] = '{32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          34, 1'b0};
        vecs[7] = '{32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  34, 1'b0};
        vecs[8] = '{32'h8000_0000,  32'd3,          1'b0, 32'h2AAA_AAAA,  32'd2,          34, 1'b0};
        vecs[9] = '{32'hFFFF_FFF8,  32'hFFFF_FFFD,  1'b1, 32'd2,          32'hFFFF_FFFE,  34, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hi",   bus.Hi, 32'd0);
        chk("reset_lo",   bus.Lo, 32'd0);
        chk("reset_busy", {31'd0, bus.Busy}, 32'd0);
        chk("reset_done", {31'd0, bus.Done}, 32'd0);
        chk("reset_dz",   {31'd0, bus.DivZero}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_div(vecs[i].a, vecs[i].b, vecs[i].s, lat, dz);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_divzero", i), {31'd0, dz}, {31'd0, vecs[i].dz});
            chk($sformatf("v%0d_lo", i), bus.Lo, vecs[i].lo);
            chk($sformatf("v%0d_hi", i), bus.Hi, vecs[i].hi);
            @(negedge clk);
            chk($sformatf("v%0d_busy_after", i), {31'd0, bus.Busy}, 32'd0);
        end

        // Start held high while busy, operands changed, Start still high in DONE.
        @(negedge clk);
        bus.A = 32'd50; bus.B = 32'd5; bus.Signed = 1'b0; bus.Start = 1'b1;
        @(negedge clk);
        bus.A = 32'd99; bus.B = 32'd2; bus.Signed = 1'b1;
        ndone = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.Done) begin
                ndone++;
                bus.Start = 1'b0;
            end
        end
        bus.Start = 1'b0;
        chk("held_start_done_count", ndone, 1);
        chk("held_start_lo", bus.Lo, 32'd10);
        chk("held_start_hi", bus.Hi, 32'd0);
        chk("held_start_busy", {31'd0, bus.Busy}, 32'd0);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        bus.A = 32'd1000; bus.B = 32'd3; bus.Signed = 1'b0; bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_lo",   bus.Lo, 32'd0);
        chk("abort_hi",   bus.Hi, 32'd0);
        chk("abort_busy", {31'd0, bus.Busy}, 32'd0);
        chk("abort_done", {31'd0, bus.Done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.Done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        do_div(32'd1000, 32'd3, 1'b0, lat, dz);
        chk("post_reset_latency", lat, 34);
        chk("post_reset_lo", bus.Lo, 32'd333);
        chk("post_reset_hi", bus.Hi, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle integer divider for the MIPS multicycle CPU, serving DIV/DIVU.
- Sits beside the multiplier, downstream of the A/B operand registers (fed their uncomplemented outputs).
- Produces HI (remainder) and LO (quotient), which the register-write data mux consumes exactly as it consumes the multiplier product halves.
- Handshakes with the control unit through a Start/Busy/Done protocol so the FSM can wait on completion.

Parameters:
WIDTH, 32, operand and result width in bits.

Ports:
Clk  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-low reset.
Start  input  1  request a division; sampled only in IDLE.
Signed  input  1  1 = DIV (two's complement), 0 = DIVU; latched with Start.
A  input  WIDTH  dividend; latched with Start.
B  input  WIDTH  divisor; latched with Start.
Hi  output  WIDTH  remainder of the last completed division.
Lo  output  WIDTH  quotient of the last completed division.
Busy  output  1  high in every state except IDLE.
Done  output  1  one-cycle pulse when Hi/Lo become valid.
DivZero  output  1  one-cycle pulse, coincident with Done, when B was 0.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low.
- Reset values: state=IDLE, Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, internal counter/remainder/quotient=0.
- Reset asserted mid-operation aborts immediately to IDLE with the values above. No partial result is kept.
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - On an edge with Start=1: latch A, B, Signed; go to PREP.
  - Start=0: stay in IDLE.
- PREP:
  - If latched B==0: go to DONE with DivZero flag set. Hi/Lo are not modified.
  - Otherwise: form magnitudes. If Signed, take the absolute value of negative operands; else use operands as unsigned.
  - Record neg_q = Signed & (A[31]^B[31]) and neg_r = Signed & A[31].
  - Clear the partial remainder, load the dividend magnitude into the quotient shift register, set count=0, go to CALC.
- CALC (restoring, one bit per cycle):
  - Shift {rem, quo} left by 1.
  - Compute trial = rem_shifted − divisor_mag using a WIDTH+1-bit subtract.
  - If trial ≥ 0: rem = trial, quo LSB = 1. Else rem unchanged, quo LSB = 0.
  - count increments; after WIDTH iterations (count reaches WIDTH−1 on the last one) go to FIX.
- FIX:
  - Lo = neg_q ? −quo : quo.
  - Hi = neg_r ? −rem : rem.
  - Go to DONE.
- DONE:
  - Done=1 for exactly this cycle; DivZero=1 in this cycle only if the zero-divisor path was taken.
  - Unconditionally return to IDLE on the next edge.
  - A Start in DONE is ignored; it must be re-presented in IDLE.
- Latency:
  - Start sampled at edge 0 → Done high in the cycle after edge WIDTH+2 (edge 34 for WIDTH=32).
  - Divide-by-zero: Done high in the cycle after edge 1.
- Busy/Start interaction: Busy=1 from PREP through DONE inclusive. Start while Busy is ignored. Changes on A/B/Signed after latching have no effect.
- Hi/Lo hold their values between operations and update only in FIX.
- Overflow case, Signed −2^31 / −1: the magnitude quotient 2^31 is not negated (neg_q=0). Result is Lo=0x80000000, Hi=0. No flag is raised.
- Arithmetic: all negation is two's complement modulo 2^WIDTH. Remainder magnitude is always < divisor magnitude.

Test Plan:
- Unsigned 100/7 (Signed=0, A=100, B=7, Start 1 cycle) → Done pulse exactly 34 edges after Start, Lo=14, Hi=2, DivZero=0, Busy low the following cycle.
- Signed −7/2 (A=0xFFFFFFF9, B=2, Signed=1) → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Signed 7/−2 → Lo=0xFFFFFFFD, Hi=1.
- Divide by zero (A=0x1234, B=0, prior Hi=2/Lo=14) → Done and DivZero high together in the cycle after edge 1; Hi=2, Lo=14 unchanged.
- Boundary operands:
  - Unsigned 0xFFFFFFFF/1 → Lo=0xFFFFFFFF, Hi=0.
  - Signed 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0.
  - Unsigned 5/9 → Lo=0, Hi=5.
- Start held high and A/B changed while Busy → only one Done. Result matches the operands latched at the first Start. A Start in the DONE cycle produces no second run.
- Reset driven low at edge 10 of a running division (asynchronously, between edges) → Hi/Lo/Busy/Done go to 0 immediately. No Done appears afterward. A new Start after release gives a correct result with normal latency.
